// File: rtl/mem_port_arbiter.sv
// Round-robin two-master arbiter and sequencer for the shared data-memory port.
// Optional ARB_LOCK_EN adds m0_lock/m1_lock to let the last owner keep the port.
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_we,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_we,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
`ifdef ARB_LOCK_EN
    input  logic        m0_lock,
    input  logic        m1_lock,
`endif
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_done,
    output logic        m1_done,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic [31:0] memaddr,
    output logic        memwrite,
    output logic        memread,
    output logic [31:0] writedata,
    output logic [3:0]  be,
    input  logic [31:0] readdata,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_t;

    localparam logic [3:0] CntInit = 4'(MEM_LATENCY - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_owner;
    logic        r_rr;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic        r_we;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_m0_rdata;
    logic [31:0] r_m1_rdata;
    logic        w_any_req;
    logic        w_winner;
    logic        w_drive;
    logic        w_capture;

`ifdef ARB_LOCK_EN
    logic        r_lock_vld;
    logic        r_lock_owner;
`endif

    assign w_any_req = m0_req | m1_req;

    always_comb begin
        w_winner = 1'b0;
        if (m0_req && m1_req) begin
            w_winner = r_rr;
        end else if (m1_req) begin
            w_winner = 1'b1;
        end
`ifdef ARB_LOCK_EN
        // A locked owner that requests again overrides the round-robin pointer.
        if (r_lock_vld && (r_lock_owner ? m1_req : m0_req)) begin
            w_winner = r_lock_owner;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_any_req) w_state_next = StIssue;
            StIssue: w_state_next = (r_cnt == 4'd0) ? StDone : StWait;
            StWait:  if (r_cnt == 4'd0) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    assign w_capture = ((r_state == StIssue) || (r_state == StWait)) && (r_cnt == 4'd0) && !r_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner    <= 1'b0;
            r_rr       <= 1'b0;
            r_cnt      <= 4'd0;
            r_addr     <= 32'd0;
            r_we       <= 1'b0;
            r_wdata    <= 32'd0;
            r_be       <= 4'd0;
            r_m0_rdata <= 32'd0;
            r_m1_rdata <= 32'd0;
        end else begin
            if (r_state == StIdle && w_any_req) begin
                r_owner <= w_winner;
                r_cnt   <= CntInit;
                r_addr  <= w_winner ? m1_addr : m0_addr;
                r_we    <= w_winner ? m1_we : m0_we;
                r_wdata <= w_winner ? m1_wdata : m0_wdata;
                r_be    <= w_winner ? m1_be : m0_be;
            end
            if (r_state == StIssue) begin
                r_rr <= ~r_owner;
            end
            if ((r_state == StIssue || r_state == StWait) && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                if (r_owner) begin
                    r_m1_rdata <= readdata;
                end else begin
                    r_m0_rdata <= readdata;
                end
            end
        end
    end

`ifdef ARB_LOCK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock_vld   <= 1'b0;
            r_lock_owner <= 1'b0;
        end else if (r_state == StDone) begin
            r_lock_vld   <= r_owner ? m1_lock : m0_lock;
            r_lock_owner <= r_owner;
        end else if (r_state == StIdle && w_any_req) begin
            r_lock_vld   <= 1'b0;
        end
    end
`endif

    assign w_drive = (r_state == StIssue) || (r_state == StWait);

    always_comb begin
        memaddr   = w_drive ? r_addr : 32'd0;
        writedata = w_drive ? r_wdata : 32'd0;
        be        = w_drive ? r_be : 4'd0;
        memwrite  = w_drive && r_we;
        memread   = w_drive && !r_we;
        m0_gnt    = (r_state == StIssue) && !r_owner;
        m1_gnt    = (r_state == StIssue) && r_owner;
        m0_done   = (r_state == StDone) && !r_owner;
        m1_done   = (r_state == StDone) && r_owner;
        busy      = (r_state != StIdle);
        m0_rdata  = r_m0_rdata;
        m1_rdata  = r_m1_rdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LATENCY=3 instance for most checks and a
// MEM_LATENCY=1 instance for the single-cycle path.
module tb_mem_port_arbiter;

    localparam int unsigned LAT = 3;

    typedef struct {
        logic        master;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] mem_rdata;
        logic [31:0] exp_r0;
        logic [31:0] exp_r1;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 0, m1_req = 0, m0_we = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0, readdata = 0;
    logic [3:0]  m0_be = 0, m1_be = 0;
    logic        m0_gnt, m1_gnt, m0_done, m1_done, memwrite, memread, busy;
    logic [31:0] m0_rdata, m1_rdata, memaddr, writedata;
    logic [3:0]  be;

    logic        a_m0_req = 0, a_m0_we = 0;
    logic [31:0] a_m0_addr = 0, a_readdata = 0;
    logic [3:0]  a_m0_be = 0;
    logic        a_m0_gnt, a_m1_gnt, a_m0_done, a_m1_done, a_memwrite, a_memread, a_busy;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_memaddr, a_writedata;
    logic [3:0]  a_be;

`ifdef ARB_LOCK_EN
    logic        m0_lock = 0, m1_lock = 0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata), .m1_be(m1_be),
`ifdef ARB_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_done(m0_done), .m1_done(m1_done),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .memaddr(memaddr), .memwrite(memwrite),
        .memread(memread), .writedata(writedata), .be(be), .readdata(readdata), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .m0_req(a_m0_req), .m0_addr(a_m0_addr), .m0_we(a_m0_we), .m0_wdata(32'd0),
        .m0_be(a_m0_be),
        .m1_req(1'b0), .m1_addr(32'd0), .m1_we(1'b0), .m1_wdata(32'd0), .m1_be(4'd0),
`ifdef ARB_LOCK_EN
        .m0_lock(1'b0), .m1_lock(1'b0),
`endif
        .m0_gnt(a_m0_gnt), .m1_gnt(a_m1_gnt), .m0_done(a_m0_done), .m1_done(a_m1_done),
        .m0_rdata(a_m0_rdata), .m1_rdata(a_m1_rdata), .memaddr(a_memaddr),
        .memwrite(a_memwrite), .memread(a_memread), .writedata(a_writedata), .be(a_be),
        .readdata(a_readdata), .busy(a_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
    endtask

    task automatic drive_req(input txn_t t);
        if (!t.master) begin
            m0_req = 1'b1; m0_addr = t.addr; m0_we = t.we; m0_wdata = t.wdata; m0_be = t.be;
        end else begin
            m1_req = 1'b1; m1_addr = t.addr; m1_we = t.we; m1_wdata = t.wdata; m1_be = t.be;
        end
        readdata = t.mem_rdata;
    endtask

    // Scramble request fields after grant so an unlatched datapath shows up.
    task automatic clear_reqs(input logic junk_we);
        m0_req = 1'b0; m1_req = 1'b0;
        m0_addr = 32'hBAD0BAD0; m1_addr = 32'hBAD0BAD0;
        m0_wdata = 32'h0BAD0BAD; m1_wdata = 32'h0BAD0BAD;
        m0_we = junk_we; m1_we = junk_we;
        m0_be = 4'h5; m1_be = 4'h5;
    endtask

    task automatic run_txn(input txn_t t);
        drive_req(t);
        for (int c = 1; c <= int'(LAT); c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("gnt", 32'({m1_gnt, m0_gnt}), t.master ? 32'd2 : 32'd1);
                chk("busy_active", 32'(busy), 32'd1);
                clear_reqs(~t.we);
            end else begin
                chk("gnt_pulse", 32'({m1_gnt, m0_gnt}), 32'd0);
            end
            chk("mem_addr", memaddr, t.addr);
            chk("mem_wdata", writedata, t.wdata);
            chk("mem_ctl", 32'({be, memwrite, memread}), 32'({t.be, t.we, ~t.we}));
        end
        @(negedge clk);
        chk("done", 32'({m1_done, m0_done}), t.master ? 32'd2 : 32'd1);
        chk("port_idle", memaddr | writedata | 32'({be, memwrite, memread}), 32'd0);
        chk("rdata0", m0_rdata, t.exp_r0);
        chk("rdata1", m1_rdata, t.exp_r1);
        @(negedge clk);
        chk("busy_idle", 32'({busy, m1_done, m0_done}), 32'd0);
    endtask

    // Caller drives the requests; records up to four grants (master and cycle).
    task automatic capture_grants(input int ncyc, output logic [3:0] who,
                                  output logic [3:0][7:0] at, output int ngr);
        who = '0;
        at  = '0;
        ngr = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (m0_gnt || m1_gnt) begin
                if (ngr < 4) begin
                    who[ngr] = m1_gnt;
                    at[ngr]  = 8'(c);
                end
                ngr++;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        for (int c = 0; c < 10 && busy; c++) @(negedge clk);
        chk("drain_idle", 32'(busy), 32'd0);
    endtask

    txn_t vec[6];
    txn_t post_rst;
    logic [3:0]      g_who;
    logic [3:0][7:0] g_at;
    int              g_n;
    int              done_c, gnt_c, m1done_c, drv, dones;

    initial begin
        vec[0] = '{1'b0, 1'b0, 32'h00000100, 32'h00000000, 4'hF, 32'hCAFEF00D,
                   32'hCAFEF00D, 32'h00000000};
        vec[1] = '{1'b1, 1'b1, 32'h00000020, 32'h12345678, 4'hF, 32'hFFFFFFFF,
                   32'hCAFEF00D, 32'h00000000};
        vec[2] = '{1'b1, 1'b0, 32'h00000024, 32'h00000000, 4'h3, 32'hA5A55A5A,
                   32'hCAFEF00D, 32'hA5A55A5A};
        vec[3] = '{1'b0, 1'b1, 32'h00000103, 32'hFFFF0000, 4'h0, 32'h77777777,
                   32'hCAFEF00D, 32'hA5A55A5A};
        vec[4] = '{1'b0, 1'b0, 32'h00000000, 32'h00000000, 4'h0, 32'h00000001,
                   32'h00000001, 32'hA5A55A5A};
        vec[5] = '{1'b1, 1'b1, 32'hFFFFFFFC, 32'h89ABCDEF, 4'h8, 32'h00000000,
                   32'h00000001, 32'hA5A55A5A};
        post_rst = '{1'b1, 1'b0, 32'h00000080, 32'h00000000, 4'hF, 32'h13579BDF,
                     32'h00000000, 32'h13579BDF};

        // Reset state of both instances
        @(negedge clk);
        @(negedge clk);
        chk("rst_data", memaddr | writedata | m0_rdata | m1_rdata, 32'd0);
        chk("rst_ctl", 32'({be, memwrite, memread, m0_gnt, m1_gnt, m0_done, m1_done, busy}),
            32'd0);
        chk("rst_l1", a_memaddr | a_writedata | a_m0_rdata | a_m1_rdata |
            32'({a_be, a_memwrite, a_memread, a_m0_gnt, a_m1_gnt, a_m0_done, a_m1_done,
                 a_busy}), 32'd0);
        reset = 1'b0;

        // Single-cycle latency read
        a_m0_req = 1'b1; a_m0_addr = 32'h10; a_m0_we = 1'b0; a_m0_be = 4'hF;
        a_readdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("l1_gnt", 32'({a_m1_gnt, a_m0_gnt, a_memread, a_memwrite}), 32'b0110);
        chk("l1_addr", a_memaddr, 32'h10);
        a_m0_req = 1'b0; a_m0_addr = 32'hBAD0BAD0;
        @(negedge clk);
        chk("l1_done", 32'({a_m1_done, a_m0_done, a_memread, a_memwrite}), 32'b0100);
        chk("l1_rdata", a_m0_rdata, 32'hDEADBEEF);
        a_readdata = 32'h0;
        @(negedge clk);
        chk("l1_idle", 32'({a_busy, a_m0_done}), 32'd0);
        chk("l1_rdata_hold", a_m0_rdata, 32'hDEADBEEF);

        for (int i = 0; i < 6; i++) run_txn(vec[i]);

        // m1 raised while m0 is in WAIT
        drive_req('{1'b0, 1'b0, 32'h00000200, 32'h0, 4'hF, 32'h0BADF00D, 32'h0, 32'h0});
        @(negedge clk);
        chk("ovl_m0_gnt", 32'(m0_gnt), 32'd1);
        clear_reqs(1'b1);
        done_c = -1; gnt_c = -1; m1done_c = -1; drv = 0;
        for (int c = 2; c <= 12; c++) begin
            @(negedge clk);
            if (m0_done) done_c = c;
            if (m1_gnt) begin
                gnt_c = c;
                m1_req = 1'b0;
            end
            if (m1_done) m1done_c = c;
            if (memread || memwrite) drv++;
            if (c == 2) begin
                m1_req = 1'b1; m1_addr = 32'h30; m1_we = 1'b0; m1_be = 4'hF;
            end
            if (c == 4) readdata = 32'h600DCAFE;
        end
        chk("ovl_m0_done_cyc", 32'(done_c), 32'd4);
        chk("ovl_m1_gnt_cyc", 32'(gnt_c), 32'd6);
        chk("ovl_m1_done_cyc", 32'(m1done_c), 32'd9);
        chk("ovl_drive_cycles", 32'(drv), 32'd5);
        chk("ovl_rdata0", m0_rdata, 32'h0BADF00D);
        chk("ovl_rdata1", m1_rdata, 32'h600DCAFE);

        // Reset in the middle of a write's WAIT phase
        drive_req('{1'b0, 1'b1, 32'h00000040, 32'h55AA55AA, 4'hF, 32'h0, 32'h0, 32'h0});
        @(negedge clk);
        clear_reqs(1'b0);
        @(negedge clk);
        chk("mid_memwrite", 32'(memwrite), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst_async", 32'({memwrite, memread, busy, m0_done, m1_done}), 32'd0);
        chk("rst_async_addr", memaddr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (m0_done || m1_done || busy) dones++;
        end
        chk("rst_no_done", 32'(dones), 32'd0);
        run_txn(post_rst);

        // Both masters held continuously: round-robin from reset
        do_reset();
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
        readdata = 32'h0;
        capture_grants(25, g_who, g_at, g_n);
        chk("rr_count", 32'(g_n), 32'd5);
        chk("rr_order", 32'(g_who), 32'b1010);
        chk("rr_times", 32'(g_at), {8'd16, 8'd11, 8'd6, 8'd1});

`ifdef ARB_LOCK_EN
        do_reset();
        m0_lock = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1;
        capture_grants(12, g_who, g_at, g_n);
        chk("lock_order", 32'(g_who[2:0]), 32'b000);
        do_reset();
        m0_lock = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1;
        capture_grants(12, g_who, g_at, g_n);
        chk("unlock_order", 32'(g_who[2:0]), 32'b010);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
